iter_shifter: RTL and testbench



---
 rtl/iter_shifter_if.sv | 27 ++
 rtl/iter_shifter.sv | 104 ++++++++++
 tb/tb_iter_shifter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/iter_shifter_if.sv
// Request/response bundle for the iterative shifter.
// Both sides use a valid/ready handshake.
interface iter_shifter_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   shamt;
  logic [1:0]       op_type;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             busy;

  modport master (
    output in_valid, a, shamt, op_type, out_ready,
    input  in_ready, out_valid, r, busy
  );

  modport slave (
    input  in_valid, a, shamt, op_type, out_ready,
    output in_ready, out_valid, r, busy
  );
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit: at most STEP bit positions per cycle.
// Ops: 00 SLL, 01 SRL, 10 SRA, 11 ROR. One operation in flight.
module iter_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic          clk,
  input logic          rst,
  iter_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHW:0] STEP_K = (SHW+1)'(STEP);
  localparam logic [SHW:0] W_K    = (SHW+1)'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [SHW:0]            k;
  logic [WIDTH-1:0]        shifted;
  logic signed [WIDTH-1:0] sra;
  logic [WIDTH-1:0]        ror;

  // k never reaches WIDTH, since remaining is below WIDTH
  always_comb begin
    k = ({1'b0, rem_q} > STEP_K) ? STEP_K : {1'b0, rem_q};
    sra = $signed(r_q) >>> k;
    ror = (r_q >> k) | (r_q << (W_K - k));
    shifted = r_q;
    unique case (op_q)
      2'b00: shifted = r_q << k;
      2'b01: shifted = r_q >> k;
      2'b10: shifted = sra;
      2'b11: shifted = ror;
      default: shifted = r_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    rem_d   = rem_q;
    op_d    = op_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          r_d     = bus.a;
          rem_d   = bus.shamt;
          op_d    = bus.op_type;
          state_d = (bus.shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        r_d   = shifted;
        rem_d = rem_q - k[SHW-1:0];
        if ({1'b0, rem_q} == k) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      rem_q       <= '0;
      op_q        <= 2'b00;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      rem_q       <= rem_d;
      op_q        <= op_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.r         = r_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: a 32-bit/STEP=4 and a 16-bit/STEP=1 instance.
// Vector table, corner-case sequences and random ops vs. a golden model.
module tb_iter_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32, rst16;
  logic        sel16;
  logic        v, ordy;
  logic [31:0] da;
  logic [4:0]  dsh;
  logic [1:0]  dty;

  iter_shifter_if #(.WIDTH(32)) b32 ();
  iter_shifter_if #(.WIDTH(16)) b16 ();

  assign b32.in_valid  = v & ~sel16;
  assign b32.a         = da;
  assign b32.shamt     = dsh;
  assign b32.op_type   = dty;
  assign b32.out_ready = ordy;
  assign b16.in_valid  = v & sel16;
  assign b16.a         = da[15:0];
  assign b16.shamt     = dsh[3:0];
  assign b16.op_type   = dty;
  assign b16.out_ready = ordy;

  iter_shifter #(.WIDTH(32), .STEP(4)) dut32 (
    .clk(clk), .rst(rst32), .bus(b32.slave)
  );
  iter_shifter #(.WIDTH(16), .STEP(1)) dut16 (
    .clk(clk), .rst(rst16), .bus(b16.slave)
  );

  logic        o_rdy, o_vld, o_busy;
  logic [31:0] o_r;
  assign o_rdy  = sel16 ? b16.in_ready  : b32.in_ready;
  assign o_vld  = sel16 ? b16.out_valid : b32.out_valid;
  assign o_busy = sel16 ? b16.busy      : b32.busy;
  assign o_r    = sel16 ? {16'h0, b16.r} : b32.r;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] gold(input logic [31:0] a, input int sh,
                                       input logic [1:0] ty, input int w);
    logic [31:0] m, x, fill;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    x = a & m;
    case (ty)
      2'b00: return (x << sh) & m;
      2'b01: return x >> sh;
      2'b10: begin
        fill = x[w-1] ? (m & ~(m >> sh)) : 32'h0;
        return (x >> sh) | fill;
      end
      default: return ((x >> sh) | (x << (w - sh))) & m;
    endcase
  endfunction

  function automatic int exp_lat(input logic s16, input int sh);
    int st;
    st = s16 ? 1 : 4;
    return 1 + (sh + st - 1) / st;
  endfunction

  task automatic pop_chk(input string nm);
    if (sb.size() == 0) chk({nm, "_sb_empty"}, 32'h0, 32'h1);
    else chk(nm, o_r, sb.pop_front());
  endtask

  // Accept one request, wait for the result, handshake it immediately.
  task automatic run_op(input logic s, input logic [31:0] a,
                        input logic [4:0] sh, input logic [1:0] ty,
                        input logic [31:0] exp, input int lat,
                        input string nm);
    int n;
    sel16 = s;
    ordy  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_rdy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk({nm, "_rdy_timeout"}, 32'h0, 32'h1);
    v = 1'b1; da = a; dsh = sh; dty = ty;
    sb.push_back(exp);
    @(negedge clk);
    v = 1'b0;
    n = 1;
    while (!o_vld && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(lat));
    pop_chk({nm, "_r"});
    @(negedge clk);
    chk({nm, "_rdy_after"}, {31'h0, o_rdy}, 32'h1);
    chk({nm, "_vld_after"}, {31'h0, o_vld}, 32'h0);
  endtask

  typedef struct {
    logic        s16;
    logic [31:0] a;
    logic [4:0]  sh;
    logic [1:0]  ty;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tv[12];

  initial begin
    int n;
    logic [31:0] ra;
    logic [4:0]  rs;
    logic [1:0]  rt;

    tv[0]  = '{1'b0, 32'h0000_0001, 5'd5,  2'b00, 32'h0000_0020, 3};
    tv[1]  = '{1'b0, 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 9};
    tv[2]  = '{1'b0, 32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 9};
    tv[3]  = '{1'b0, 32'h0000_00F1, 5'd4,  2'b11, 32'h1000_000F, 2};
    tv[4]  = '{1'b0, 32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678, 1};
    tv[5]  = '{1'b0, 32'h1234_5678, 5'd0,  2'b11, 32'h1234_5678, 1};
    tv[6]  = '{1'b1, 32'h0000_C000, 5'd3,  2'b10, 32'h0000_F800, 4};
    tv[7]  = '{1'b0, 32'h1234_5678, 5'd8,  2'b11, 32'h7812_3456, 3};
    tv[8]  = '{1'b0, 32'hF000_0000, 5'd4,  2'b01, 32'h0F00_0000, 2};
    tv[9]  = '{1'b0, 32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000, 9};
    tv[10] = '{1'b1, 32'h0000_0001, 5'd1,  2'b11, 32'h0000_8000, 2};
    tv[11] = '{1'b1, 32'h0000_8000, 5'd15, 2'b01, 32'h0000_0001, 16};

    sel16 = 1'b0; v = 1'b0; ordy = 1'b0;
    da = '0; dsh = '0; dty = '0;
    rst32 = 1'b1; rst16 = 1'b1;
    repeat (2) @(negedge clk);
    rst32 = 1'b0; rst16 = 1'b0;

    chk("rst32_r",    b32.r,                 32'h0);
    chk("rst32_vld",  {31'h0, b32.out_valid}, 32'h0);
    chk("rst32_rdy",  {31'h0, b32.in_ready},  32'h1);
    chk("rst32_busy", {31'h0, b32.busy},      32'h0);
    chk("rst16_r",    {16'h0, b16.r},         32'h0);
    chk("rst16_rdy",  {31'h0, b16.in_ready},  32'h1);

    for (int i = 0; i < 12; i++)
      run_op(tv[i].s16, tv[i].a, tv[i].sh, tv[i].ty, tv[i].exp,
             tv[i].lat, $sformatf("vec%0d", i));

    // Backpressure with a competing request held high
    sel16 = 1'b0; ordy = 1'b0;
    @(negedge clk);
    v = 1'b1; da = 32'h3; dsh = 5'd2; dty = 2'b00;
    sb.push_back(32'hC);
    @(negedge clk);
    v = 1'b0;
    chk("bp_busy", {31'h0, o_busy}, 32'h1);
    n = 1;
    while (!o_vld && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("bp_lat", 32'(n), 32'd2);
    v = 1'b1; da = 32'h0000_00F0; dsh = 5'd1; dty = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_r%0d", i),   o_r,             32'hC);
      chk($sformatf("bp_vld%0d", i), {31'h0, o_vld},  32'h1);
      chk($sformatf("bp_rdy%0d", i), {31'h0, o_rdy},  32'h0);
    end
    pop_chk("bp_result");
    ordy = 1'b1;
    sb.push_back(32'h1E0);
    @(negedge clk);
    chk("bp_idle_rdy",  {31'h0, o_rdy},  32'h1);
    chk("bp_idle_vld",  {31'h0, o_vld},  32'h0);
    chk("bp_idle_busy", {31'h0, o_busy}, 32'h0);
    @(negedge clk);
    v = 1'b0;
    chk("bp_new_busy", {31'h0, o_busy}, 32'h1);
    n = 1;
    while (!o_vld && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("bp_new_lat", 32'(n), 32'd2);
    pop_chk("bp_new_r");
    @(negedge clk);

    // Reset in the middle of a long SRA
    sel16 = 1'b0;
    v = 1'b1; da = 32'h8000_0000; dsh = 5'd31; dty = 2'b10;
    @(negedge clk);
    v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", {31'h0, o_busy}, 32'h1);
    rst32 = 1'b1;
    @(negedge clk);
    rst32 = 1'b0;
    chk("mid_rst_r",    o_r,             32'h0);
    chk("mid_rst_vld",  {31'h0, o_vld},  32'h0);
    chk("mid_rst_rdy",  {31'h0, o_rdy},  32'h1);
    chk("mid_rst_busy", {31'h0, o_busy}, 32'h0);
    run_op(1'b0, 32'h3, 5'd1, 2'b00, 32'h6, 2, "post_rst");

    // Reset and request together: nothing captured
    rst32 = 1'b1; v = 1'b1; da = 32'hFF; dsh = 5'd4; dty = 2'b01;
    @(negedge clk);
    rst32 = 1'b0; v = 1'b0;
    @(negedge clk);
    chk("rstreq_busy", {31'h0, o_busy}, 32'h0);
    chk("rstreq_rdy",  {31'h0, o_rdy},  32'h1);
    chk("rstreq_r",    o_r,             32'h0);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rs = 5'($urandom_range(0, 15));
      rt = 2'($urandom_range(0, 3));
      run_op(1'b1, ra, rs, rt, gold(ra, int'(rs), rt, 16),
             exp_lat(1'b1, int'(rs)), "rnd16");
    end
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rs = 5'($urandom_range(0, 31));
      rt = 2'($urandom_range(0, 3));
      run_op(1'b0, ra, rs, rt, gold(ra, int'(rs), rt, 32),
             exp_lat(1'b0, int'(rs)), "rnd32");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
